// File: rtl/swipt_pwm_gen.sv
// Complementary half-bridge PWM with dead-time around each switching edge.
// Duty is shadow-latched at period boundaries; link loss aborts immediately.
module swipt_pwm_gen #(
    parameter int PERIOD   = 500,
    parameter int DEADTIME = 8,
    parameter int WIDTH    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             swiptAlive,
    input  logic             enable,
    input  logic [WIDTH-1:0] dutyCycle,
    output logic             gateHigh,
    output logic             gateLow,
    output logic             periodStart,
    output logic [WIDTH-1:0] dutyApplied,
    output logic             running
);

    localparam int CW = $clog2(PERIOD);
    localparam logic [WIDTH:0]   PERIOD_W = (WIDTH+1)'(PERIOD);
    localparam logic [WIDTH:0]   DEAD_W   = (WIDTH+1)'(DEADTIME);
    localparam logic [CW-1:0]    LAST_CNT = CW'(PERIOD - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] d_latch_reg, d_latch_next;
    logic [WIDTH-1:0] duty_clamped;
    logic             last_cnt;
    logic             active;
    logic [WIDTH:0]   cnt_w;
    logic [WIDTH:0]   d_w;
    logic             high_next, low_next, pstart_next;

    assign last_cnt     = (cnt_reg == LAST_CNT);
    assign duty_clamped = ({1'b0, dutyCycle} > PERIOD_W) ? WIDTH'(PERIOD) : dutyCycle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            d_latch_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            d_latch_reg <= d_latch_next;
        end
    end

    // Dropping enable mid-period moves to FINISH so the current period completes;
    // dropping it on the last count simply ends the period there.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        d_latch_next = d_latch_reg;
        if (!swiptAlive) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_next = '0;
                    if (enable) begin
                        state_next   = RUN;
                        d_latch_next = duty_clamped;
                    end
                end
                RUN: begin
                    cnt_next = last_cnt ? '0 : cnt_reg + 1'b1;
                    if (enable) begin
                        if (last_cnt)
                            d_latch_next = duty_clamped;
                    end else begin
                        state_next = last_cnt ? IDLE : FINISH;
                    end
                end
                FINISH: begin
                    cnt_next = last_cnt ? '0 : cnt_reg + 1'b1;
                    if (last_cnt)
                        state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Gate decode is suppressed as soon as the link drops so both gates fall on the abort edge.
    assign active      = swiptAlive && (state_reg != IDLE);
    assign cnt_w       = (WIDTH+1)'(cnt_reg);
    assign d_w         = {1'b0, d_latch_reg};
    assign high_next   = active && (cnt_w >= DEAD_W) && (cnt_w < d_w);
    assign low_next    = active && (cnt_w >= d_w + DEAD_W) && (cnt_w < PERIOD_W);
    assign pstart_next = active && (cnt_reg == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gateHigh    <= 1'b0;
            gateLow     <= 1'b0;
            periodStart <= 1'b0;
            dutyApplied <= '0;
            running     <= 1'b0;
        end else begin
            gateHigh    <= high_next;
            gateLow     <= low_next;
            periodStart <= pstart_next;
            running     <= (state_next != IDLE);
            if (pstart_next)
                dutyApplied <= d_latch_reg;
        end
    end

    gates_exclusive: assert property (@(posedge clk) disable iff (rst) !(gateHigh && gateLow));

endmodule

// File: tb/tb_swipt_pwm_gen.sv
// Scoreboarded bench for swipt_pwm_gen: per-period expectations from a duty model,
// plus directed abort, graceful-stop, restart and asynchronous-reset scenarios.
module tb_swipt_pwm_gen;

    localparam int PERIOD = 500;
    localparam int DT     = 8;
    localparam int W      = 12;
    localparam int NPER   = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         swiptAlive = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] dutyCycle = '0;
    logic         gateHigh, gateLow, periodStart, running;
    logic [W-1:0] dutyApplied;

    always #5 clk = ~clk;

    swipt_pwm_gen #(.PERIOD(PERIOD), .DEADTIME(DT), .WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .swiptAlive  (swiptAlive),
        .enable      (enable),
        .dutyCycle   (dutyCycle),
        .gateHigh    (gateHigh),
        .gateLow     (gateLow),
        .periodStart (periodStart),
        .dutyApplied (dutyApplied),
        .running     (running)
    );

    typedef struct {
        int duty;
        int hf;
        int hn;
        int lf;
        int ln;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    bit   mon_busy = 1'b0;
    int   period_no = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected period shape: high phase spans [DT, d), low phase spans [d+DT, PERIOD).
    function automatic exp_t model(input int v);
        exp_t e;
        int   d;
        d     = (v > PERIOD) ? PERIOD : v;
        e.duty = d;
        e.hn   = (d > DT) ? d - DT : 0;
        e.hf   = (e.hn > 0) ? DT : -1;
        e.ln   = (d + DT < PERIOD) ? PERIOD - d - DT : 0;
        e.lf   = (e.ln > 0) ? d + DT : -1;
        return e;
    endfunction

    function automatic int pick();
        int edges[13] = '{0, 5, 8, 9, 250, 491, 492, 493, 499, 500, 501, 2047, 4095};
        if ($urandom_range(0, 1) == 1)
            return edges[$urandom_range(0, 12)];
        return int'($urandom_range(0, 4095));
    endfunction

    task automatic wait_pstart(output int lat, input int maxc);
        bit found;
        found = 1'b0;
        lat   = 0;
        while (!found && lat < maxc) begin
            @(negedge clk);
            lat++;
            if (periodStart === 1'b1)
                found = 1'b1;
        end
        if (!found)
            lat = -1;
    endtask

    task automatic measure_period();
        exp_t e;
        int   hf, hn, hl, lf, ln, ll, extra, dut_duty;
        hf = -1; hn = 0; hl = -1; lf = -1; ln = 0; ll = -1; extra = 0;
        mon_busy = 1'b1;
        dut_duty = int'(dutyApplied);
        for (int j = 0; j < PERIOD; j++) begin
            if (j > 0)
                @(negedge clk);
            if (gateHigh === 1'b1) begin
                if (hf < 0) hf = j;
                hn++;
                hl = j;
            end
            if (gateLow === 1'b1) begin
                if (lf < 0) lf = j;
                ln++;
                ll = j;
            end
            if (j > 0 && periodStart === 1'b1)
                extra++;
        end
        if (sb_q.size() == 0) begin
            chk("unexpected_period", 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk("duty_applied", dut_duty, e.duty);
            chk("high_first", hf, e.hf);
            chk("high_count", hn, e.hn);
            chk("high_last", hl, (e.hn > 0) ? e.hf + e.hn - 1 : -1);
            chk("low_first", lf, e.lf);
            chk("low_count", ln, e.ln);
            chk("low_last", ll, (e.ln > 0) ? e.lf + e.ln - 1 : -1);
            chk("extra_pstart", extra, 0);
            $display("period %0d duty=%0d high=%0d low=%0d", period_no, dut_duty, hn, ln);
        end
        period_no++;
        mon_busy = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && periodStart === 1'b1)
                measure_period();
        end
    end

    always @(negedge clk) begin
        if (gateHigh === 1'b1 && gateLow === 1'b1) begin
            failures++;
            $display("FAIL gate_overlap: gateHigh=1 gateLow=1 (t=%0t)", $time);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    int lat, r, n, v, last_duty;

    initial begin
        #1;
        chk("rst_gateHigh", int'(gateHigh), 0);
        chk("rst_gateLow", int'(gateLow), 0);
        chk("rst_periodStart", int'(periodStart), 0);
        chk("rst_dutyApplied", int'(dutyApplied), 0);
        chk("rst_running", int'(running), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        swiptAlive = 1'b1;
        @(negedge clk);

        // Randomised periods checked by the scoreboard monitor.
        dutyCycle = 12'd250;
        sb_q.push_back(model(250));
        last_duty = 250;
        mon_en = 1'b1;
        enable = 1'b1;
        wait_pstart(lat, 10);
        chk("first_start_latency", lat, 2);
        for (int k = 0; k < NPER; k++) begin
            r = $urandom_range(1, 400);
            repeat (r) @(negedge clk);
            if (k < NPER - 1) begin
                v = (k == 0) ? 100 : pick();
                dutyCycle = W'(v);
                sb_q.push_back(model(v));
                last_duty = model(v).duty;
                wait_pstart(lat, PERIOD);
                chk("period_len", lat, PERIOD - r);
            end else begin
                enable = 1'b0;
                n = 0;
                while (running === 1'b1 && n < PERIOD + 10) begin
                    @(negedge clk);
                    n++;
                end
                chk("stop_offset", r + n, PERIOD - 1);
            end
        end
        repeat (3) begin
            @(negedge clk);
            chk("idle_quiet", int'(periodStart) + int'(gateHigh) + int'(gateLow) + int'(running), 0);
        end
        chk("duty_hold", int'(dutyApplied), last_duty);
        chk("sb_empty", sb_q.size(), 0);
        chk("monitor_idle", int'(mon_busy), 0);
        mon_en = 1'b0;

        // Link abort while gateHigh is active, then fresh restart.
        dutyCycle = 12'd250;
        enable = 1'b1;
        wait_pstart(lat, 10);
        chk("restart_latency", lat, 2);
        repeat (100) @(negedge clk);
        chk("abort_pre_high", int'(gateHigh), 1);
        swiptAlive = 1'b0;
        @(negedge clk);
        chk("abort_gates", int'(gateHigh) + int'(gateLow), 0);
        chk("abort_running", int'(running), 0);
        swiptAlive = 1'b1;
        wait_pstart(lat, 10);
        chk("realive_latency", lat, 2);
        chk("realive_duty", int'(dutyApplied), 250);
        repeat (7) @(negedge clk);
        chk("deadtime_off_cnt7", int'(gateHigh), 0);
        @(negedge clk);
        chk("deadtime_on_cnt8", int'(gateHigh), 1);

        // enable glitch inside the finishing period is ignored.
        repeat (42) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b1;
        repeat (439) @(negedge clk);
        chk("finish_running", int'(running), 0);
        chk("finish_last_low", int'(gateLow), 1);
        wait_pstart(lat, 10);
        chk("finish_restart_latency", lat, 2);

        // Asynchronous reset between clock edges.
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_gateHigh", int'(gateHigh), 0);
        chk("arst_gateLow", int'(gateLow), 0);
        chk("arst_periodStart", int'(periodStart), 0);
        chk("arst_dutyApplied", int'(dutyApplied), 0);
        chk("arst_running", int'(running), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
